// File: rtl/vga_timing_controller_pkg.sv
// Shared timing constants, coordinate type and window helper for the
// 640x480@60Hz VGA timing controller.
package vga_timing_controller_pkg;

  localparam int unsigned CW = 12;

  localparam int unsigned H_ACTIVE_DEF = 640;
  localparam int unsigned H_FP_DEF     = 16;
  localparam int unsigned H_SYNC_DEF   = 96;
  localparam int unsigned H_BP_DEF     = 48;
  localparam int unsigned H_TOTAL_DEF  = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;

  localparam int unsigned V_ACTIVE_DEF = 480;
  localparam int unsigned V_FP_DEF     = 10;
  localparam int unsigned V_SYNC_DEF   = 2;
  localparam int unsigned V_BP_DEF     = 33;
  localparam int unsigned V_TOTAL_DEF  = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

  localparam int unsigned HS_START_DEF = H_ACTIVE_DEF + H_FP_DEF;
  localparam int unsigned HS_END_DEF   = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF - 1;
  localparam int unsigned VS_START_DEF = V_ACTIVE_DEF + V_FP_DEF;
  localparam int unsigned VS_END_DEF   = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF - 1;

  localparam int unsigned COLOR_R = 2;
  localparam int unsigned COLOR_G = 1;
  localparam int unsigned COLOR_B = 0;

  typedef logic [CW-1:0] coord_t;

  // Inclusive range test used for the sync windows.
  function automatic logic in_window(input coord_t v, input coord_t lo, input coord_t hi);
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/vga_timing_controller_if.sv
// Pixel-side bundle: coordinates and color exchanged with the image generator
// plus the VGA pin outputs.
interface vga_timing_controller_if #(
  parameter int unsigned CDEPTH = 4
);
  logic [2:0]        color;
  logic [11:0]       x;
  logic [11:0]       y;
  logic              active;
  logic              frame_start;
  logic [CDEPTH-1:0] VGA_R;
  logic [CDEPTH-1:0] VGA_G;
  logic [CDEPTH-1:0] VGA_B;
  logic              VGA_HS;
  logic              VGA_VS;

  modport master (
    input  color,
    output x, y, active, frame_start,
    output VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS
  );

  modport slave (
    output color,
    input  x, y, active, frame_start,
    input  VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS
  );
endinterface

// File: rtl/vga_timing_controller_counter.sv
// Wrapping up-counter 0..MAX with enable; wrap_o flags the enabled MAX->0 step.
module vga_timing_controller_counter #(
  parameter int unsigned MAX = 799,
  parameter int unsigned W   = 12
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         en_i,
  output logic [W-1:0] cnt_o,
  output logic [W-1:0] cnt_next_o,
  output logic         wrap_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;
  logic         wrap_s;

  // next count and wrap decode
  always_comb begin
    wrap_s = 1'b0;
    cnt_d  = cnt_q;
    if (en_i && (cnt_q == W'(MAX))) begin
      wrap_s = 1'b1;
      cnt_d  = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // count register
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o      = cnt_q;
  assign cnt_next_o = cnt_d;
  assign wrap_o     = wrap_s;

endmodule

// File: rtl/vga_timing_controller.sv
// VGA raster timing: H/V counters, active and sync decode, one registered
// output stage for RGB/HS/VS, and a frame_start tick at (0,0).
module vga_timing_controller
  import vga_timing_controller_pkg::*;
#(
  parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
  parameter int unsigned H_FP     = H_FP_DEF,
  parameter int unsigned H_SYNC   = H_SYNC_DEF,
  parameter int unsigned H_BP     = H_BP_DEF,
  parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
  parameter int unsigned V_FP     = V_FP_DEF,
  parameter int unsigned V_SYNC   = V_SYNC_DEF,
  parameter int unsigned V_BP     = V_BP_DEF,
  parameter bit          SYNC_POL = 1'b0,
  parameter int unsigned CDEPTH   = 4
) (
  input  logic                           CLOCK_25,
  input  logic                           RESET_N,
  vga_timing_controller_if.master        vga
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam coord_t H_ACT_C  = coord_t'(H_ACTIVE);
  localparam coord_t V_ACT_C  = coord_t'(V_ACTIVE);
  localparam coord_t H_LAST_C = coord_t'(H_TOTAL - 1);
  localparam coord_t V_LAST_C = coord_t'(V_TOTAL - 1);
  localparam coord_t HS_LO_C  = coord_t'(H_ACTIVE + H_FP);
  localparam coord_t HS_HI_C  = coord_t'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam coord_t VS_LO_C  = coord_t'(V_ACTIVE + V_FP);
  localparam coord_t VS_HI_C  = coord_t'(V_ACTIVE + V_FP + V_SYNC - 1);

  coord_t h_cnt_s, h_next_s, v_cnt_s, v_next_s;
  logic   h_wrap_s, v_wrap_s;

  vga_timing_controller_counter #(.MAX(H_TOTAL - 1), .W(CW)) u_h_cnt (
    .clk_i      (CLOCK_25),
    .rst_ni     (RESET_N),
    .en_i       (1'b1),
    .cnt_o      (h_cnt_s),
    .cnt_next_o (h_next_s),
    .wrap_o     (h_wrap_s)
  );

  vga_timing_controller_counter #(.MAX(V_TOTAL - 1), .W(CW)) u_v_cnt (
    .clk_i      (CLOCK_25),
    .rst_ni     (RESET_N),
    .en_i       (h_wrap_s),
    .cnt_o      (v_cnt_s),
    .cnt_next_o (v_next_s),
    .wrap_o     (v_wrap_s)
  );

  logic              active_q, active_d;
  logic              fs_q, fs_d;
  logic              hs_q, hs_d;
  logic              vs_q, vs_d;
  logic [CDEPTH-1:0] r_q, r_d, g_q, g_d, b_q, b_d;

  // active tracks the counters' next value so it stays aligned with x/y;
  // the rest decodes the current position for the output stage.
  always_comb begin
    active_d = (h_next_s < H_ACT_C) && (v_next_s < V_ACT_C);
    fs_d     = (h_cnt_s == H_LAST_C) && (v_cnt_s == V_LAST_C);
    hs_d     = in_window(h_cnt_s, HS_LO_C, HS_HI_C) ? SYNC_POL : ~SYNC_POL;
    vs_d     = in_window(v_cnt_s, VS_LO_C, VS_HI_C) ? SYNC_POL : ~SYNC_POL;
    if (active_q) begin
      r_d = {CDEPTH{vga.color[COLOR_R]}};
      g_d = {CDEPTH{vga.color[COLOR_G]}};
      b_d = {CDEPTH{vga.color[COLOR_B]}};
    end else begin
      // blanking: color is ignored entirely, so X cannot leak to the pins
      r_d = '0;
      g_d = '0;
      b_d = '0;
    end
  end

  // output stage and frame tick
  always_ff @(posedge CLOCK_25) begin
    if (!RESET_N) begin
      active_q <= 1'b0;
      fs_q     <= 1'b0;
      hs_q     <= ~SYNC_POL;
      vs_q     <= ~SYNC_POL;
      r_q      <= '0;
      g_q      <= '0;
      b_q      <= '0;
    end else begin
      active_q <= active_d;
      fs_q     <= fs_d;
      hs_q     <= hs_d;
      vs_q     <= vs_d;
      r_q      <= r_d;
      g_q      <= g_d;
      b_q      <= b_d;
    end
  end

  logic unused_s;
  assign unused_s = v_wrap_s;

  assign vga.x           = h_cnt_s;
  assign vga.y           = v_cnt_s;
  assign vga.active      = active_q;
  assign vga.frame_start = fs_q;
  assign vga.VGA_R       = r_q;
  assign vga.VGA_G       = g_q;
  assign vga.VGA_B       = b_q;
  assign vga.VGA_HS      = hs_q;
  assign vga.VGA_VS      = vs_q;

endmodule

// File: tb/tb_vga_timing_controller.sv
// Directed bench for vga_timing_controller: reset state, line/frame timing,
// RGB blanking, single-pixel color and mid-frame reset.
module tb_vga_timing_controller;

  logic CLOCK_25 = 1'b0;
  logic RESET_N  = 1'b0;

  always #20 CLOCK_25 = ~CLOCK_25;

  vga_timing_controller_if #(.CDEPTH(4)) vif ();

  vga_timing_controller dut (
    .CLOCK_25 (CLOCK_25),
    .RESET_N  (RESET_N),
    .vga      (vif.master)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLOCK_25);
    #1;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_x"}, 32'(vif.x), 32'd0);
    chk({tag, "_y"}, 32'(vif.y), 32'd0);
    chk({tag, "_hs"}, 32'(vif.VGA_HS), 32'd1);
    chk({tag, "_vs"}, 32'(vif.VGA_VS), 32'd1);
    chk({tag, "_rgb"}, 32'({vif.VGA_R, vif.VGA_G, vif.VGA_B}), 32'd0);
    chk({tag, "_fs"}, 32'(vif.frame_start), 32'd0);
    chk({tag, "_act"}, 32'(vif.active), 32'd0);
  endtask

  initial begin
    int hs_low, hs_first, hs_last, rgb_on;
    int vs_low, vs_run, vs_max, vs_first, fs_cnt;
    bit pend, found;

    hs_low = 0; hs_first = -1; hs_last = -1; rgb_on = 0;
    vs_low = 0; vs_run = 0; vs_max = 0; vs_first = -1; fs_cnt = 0;
    pend = 1'b0; found = 1'b0;

    vif.color = 3'b111;
    RESET_N   = 1'b0;
    repeat (5) step();
    chk_reset_state("rst");
    RESET_N = 1'b1;

    // one full frame from release, edge k leaves counters at linear position k
    for (int k = 1; k <= 420000; k++) begin
      step();
      if (k == 1) chk("x_after_release", 32'(vif.x), 32'd1);
      if (k <= 800) begin
        if (vif.VGA_HS == 1'b0) begin
          hs_low++;
          if (hs_first < 0) hs_first = k;
          hs_last = k;
        end
        if (k >= 2 && k <= 640 && {vif.VGA_R, vif.VGA_G, vif.VGA_B} == 12'hFFF) rgb_on++;
      end
      if (k == 641) chk("rgb_blank_x640", 32'({vif.VGA_R, vif.VGA_G, vif.VGA_B}), 32'd0);
      if (k == 799) chk("xy_799_0", 32'({vif.x, vif.y}), 32'({12'd799, 12'd0}));
      if (k == 800) chk("xy_wrap_0_1", 32'({vif.x, vif.y}), 32'({12'd0, 12'd1}));
      if (k == 383840) chk("rgb_on_639_479", 32'({vif.VGA_R, vif.VGA_G, vif.VGA_B}), 32'hFFF);
      if (k == 384001) chk("rgb_blank_y480", 32'({vif.VGA_R, vif.VGA_G, vif.VGA_B}), 32'd0);
      if (pend) begin
        chk("red_pixel", 32'({vif.VGA_R, vif.VGA_G, vif.VGA_B}), 32'hF00);
        vif.color = 3'b111;
        pend = 1'b0;
      end
      if (vif.x == 12'd25 && vif.y == 12'd210) begin
        vif.color = 3'b100;
        pend = 1'b1;
      end
      if (vif.VGA_VS == 1'b0) begin
        vs_low++;
        vs_run++;
        if (vs_first < 0) vs_first = k;
        if (vs_run > vs_max) vs_max = vs_run;
      end else begin
        vs_run = 0;
      end
      if (vif.frame_start) fs_cnt++;
    end

    chk("hs_low_count", 32'(hs_low), 32'd96);
    chk("hs_first", 32'(hs_first), 32'd657);
    chk("hs_last", 32'(hs_last), 32'd752);
    chk("rgb_on_line0", 32'(rgb_on), 32'd639);
    chk("vs_low_count", 32'(vs_low), 32'd1600);
    chk("vs_consecutive", 32'(vs_max), 32'd1600);
    chk("vs_first", 32'(vs_first), 32'd392001);
    chk("fs_pulses", 32'(fs_cnt), 32'd1);
    chk("fs_at_origin", 32'(vif.frame_start), 32'd1);
    chk("xy_frame_wrap", 32'({vif.x, vif.y}), 32'd0);

    // run to (700,490) inside both sync pulses, then reset mid-frame
    for (int k = 0; k < 420000; k++) begin
      if (vif.x == 12'd700 && vif.y == 12'd490) begin
        found = 1'b1;
        break;
      end
      step();
    end
    chk("reach_700_490", 32'(found), 32'd1);
    chk("hs_active_pre", 32'(vif.VGA_HS), 32'd0);
    chk("vs_active_pre", 32'(vif.VGA_VS), 32'd0);
    RESET_N = 1'b0;
    step();
    chk_reset_state("midrst");
    RESET_N = 1'b1;
    fs_cnt = 0;
    for (int k = 0; k < 2000; k++) begin
      step();
      if (vif.frame_start) fs_cnt++;
    end
    chk("no_fs_after_rst", 32'(fs_cnt), 32'd0);
    chk("xy_after_rst", 32'({vif.x, vif.y}), 32'({12'd400, 12'd2}));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
